binary_to_bcd: RTL and testbench

Converts an unsigned 8-bit binary value into packed BCD digits (hundreds, tens, ones) for the seven-segment display path of the iRobot figure-8 controller. Conversion is purely arithmetic (shift-and-add-3 / double dabble) and completes within one clock. Results are captured in an output register, so digits change only on a clock edge.

---
 rtl/bcd_pkg.sv | 10 +
 rtl/bcd_add3.sv | 11 +
 rtl/binary_to_bcd.sv | 64 ++++++
 tb/tb_binary_to_bcd.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths and digit type for the binary-to-BCD converter
package bcd_pkg;
  localparam int BIN_W   = 8;
  localparam int DIGIT_W = 4;
  localparam int HUND_W  = 2;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t ADD3_THRESH = 4'd5;
endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble correction cell: digits of 5 or more get +3 before the shift
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/binary_to_bcd.sv
// rtl/binary_to_bcd.sv - unrolled double-dabble array feeding a registered hundreds/tens/ones output
module binary_to_bcd
  import bcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BIN_W-1:0]  binary,
  output logic [HUND_W-1:0] hundreds,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic              valid
);

  localparam int ACC_W = HUND_W + 2 * DIGIT_W;

  // acc[i] holds {hundreds, tens, ones} after i bits have been shifted in
  logic [BIN_W:0][ACC_W-1:0] acc;

  assign acc[0] = '0;

  for (genvar i = 0; i < BIN_W; i++) begin : g_stage
    bcd_digit_t ones_adj;
    bcd_digit_t tens_adj;

    bcd_add3 u_ones (.din(acc[i][DIGIT_W-1:0]),         .dout(ones_adj));
    bcd_add3 u_tens (.din(acc[i][2*DIGIT_W-1:DIGIT_W]), .dout(tens_adj));

    // Hundreds never reaches 5, so it is shifted without a correction cell.
    assign acc[i+1] = ({acc[i][ACC_W-1:2*DIGIT_W], tens_adj, ones_adj} << 1)
                    | ACC_W'(binary[BIN_W-1-i]);
  end

  logic [HUND_W-1:0]  hundreds_d, hundreds_q;
  bcd_digit_t         tens_d, tens_q;
  bcd_digit_t         ones_d, ones_q;
  logic               valid_d, valid_q;

  always_comb begin
    hundreds_d = acc[BIN_W][ACC_W-1:2*DIGIT_W];
    tens_d     = acc[BIN_W][2*DIGIT_W-1:DIGIT_W];
    ones_d     = acc[BIN_W][DIGIT_W-1:0];
    valid_d    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hundreds_q <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      hundreds_q <= hundreds_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      valid_q    <= valid_d;
    end
  end

  assign hundreds = hundreds_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// tb/tb_binary_to_bcd.sv - scoreboard bench for binary_to_bcd against an arithmetic digit model
module tb_binary_to_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] binary = 8'd200;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       valid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int h;
    int t;
    int o;
    int v;
    int in_val;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  binary_to_bcd dut (
    .clk      (clk),
    .reset    (reset),
    .binary   (binary),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .valid    (valid)
  );

  function automatic exp_t model(input logic r, input int val);
    exp_t e;
    e.in_val = val;
    if (r) begin
      e.h = 0; e.t = 0; e.o = 0; e.v = 0;
    end else begin
      e.h = val / 100;
      e.t = (val / 10) % 10;
      e.o = val % 10;
      e.v = 1;
    end
    return e;
  endfunction

  task automatic drive(input logic r, input int val);
    @(negedge clk);
    reset  = r;
    binary = 8'(val);
    exp_q.push_back(model(r, val));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int'(hundreds) != e.h || int'(tens) != e.t || int'(ones) != e.o || int'(valid) != e.v) begin
        failures++;
        $display("FAIL digits in=%0d got h/t/o/v=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 e.in_val, hundreds, tens, ones, valid, e.h, e.t, e.o, e.v);
      end
      checks++;
      if (tens > 4'd9 || ones > 4'd9 || hundreds > 2'd2) begin
        failures++;
        $display("FAIL bcd_range got h/t/o=%0d/%0d/%0d want h<=2 t<=9 o<=9", hundreds, tens, ones);
      end
      if (e.v == 1) begin
        checks++;
        if (100 * int'(hundreds) + 10 * int'(tens) + int'(ones) != e.in_val) begin
          failures++;
          $display("FAIL invariant got %0d want %0d",
                   100 * int'(hundreds) + 10 * int'(tens) + int'(ones), e.in_val);
        end
      end
    end
  end

  initial begin
    int boundary[6] = '{0, 9, 10, 99, 100, 255};
    int seq[3] = '{43, 21, 30};

    drive(1'b1, 200);
    drive(1'b1, 200);

    foreach (seq[i]) drive(1'b0, seq[i]);
    foreach (boundary[i]) drive(1'b0, boundary[i]);

    for (int v = 0; v < 256; v++) drive(1'b0, v);

    for (int v = 130; v < 145; v++) drive(v == 137, v);

    // two input changes between the same pair of edges; only the last one counts
    drive(1'b0, 0);
    @(negedge clk);
    reset  = 1'b0;
    binary = 8'd43;
    #2;
    binary = 8'd21;
    exp_q.push_back(model(1'b0, 21));
    #2;
    checks++;
    if (tens == 4'd4 && ones == 4'd3) begin
      failures++;
      $display("FAIL glitch_visible got t/o=%0d/%0d want not 4/3", tens, ones);
    end

    for (int n = 0; n < 200; n++) drive($urandom_range(0, 15) == 0, int'($urandom_range(0, 255)));

    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL drain got pending=%0d want 0", exp_q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
